// File: rtl/alu_cmd_sequencer.sv
// Purpose : sequences single ALU commands. It holds the operands on the ALU_TOP inputs,
//           waits RESULT_LAT cycles, then returns the selected unit's result as a response.
// Latency : a command accepted in cycle t gives RSP_VALID from cycle t+2+RESULT_LAT.
// Backpr. : one command in flight. CMD_READY is high only in IDLE. A response is held
//           stable until RSP_READY is seen.
// Ports   : CLK/RST         - clock, synchronous active-high reset
//           CMD_*           - command valid/ready handshake, operands, function code
//           A/B/ALU_FUN     - registered drive to the ALU_TOP inputs
//           *_OUT/*_Flag    - ALU_TOP unit results and per-unit valid flags
//           RSP_*           - response valid/ready handshake, data, carry, function, error
//           CMD_CNT         - count of completed responses, wraps at 256
module alu_cmd_sequencer #(
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  input  logic [3:0]  CMD_FUN,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] Arith_OUT,
  input  logic        Carry_OUT,
  input  logic [15:0] Logic_OUT,
  input  logic [3:0]  CMP_OUT,
  input  logic [15:0] SHIFT_OUT,
  input  logic        Arith_Flag,
  input  logic        Logic_Flag,
  input  logic        CMP_Flag,
  input  logic        SHIFT_Flag,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        RSP_CARRY,
  output logic [3:0]  RSP_FUN,
  output logic        RSP_ERR,
  output logic [7:0]  CMD_CNT
);

  // Compare with a zero function code is a harmless idle pattern for the ALU.
  localparam logic [3:0] FUN_NOP = 4'b1000;
  localparam logic [3:0] LAT_CNT = 4'(RESULT_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] sel_data;
  logic        sel_carry;
  logic        sel_flag;

  // The unit is chosen from the registered ALU_FUN, which holds the accepted command.
  always_comb begin
    sel_data  = '0;
    sel_carry = 1'b0;
    sel_flag  = 1'b0;
    case (ALU_FUN[3:2])
      2'b00: begin
        sel_data  = Arith_OUT;
        sel_carry = Carry_OUT;
        sel_flag  = Arith_Flag;
      end
      2'b01: begin
        sel_data = Logic_OUT;
        sel_flag = Logic_Flag;
      end
      2'b10: begin
        sel_data = {12'h000, CMP_OUT};
        sel_flag = CMP_Flag;
      end
      default: begin
        sel_data = SHIFT_OUT;
        sel_flag = SHIFT_Flag;
      end
    endcase
  end

  assign CMD_READY = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= FUN_NOP;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_FUN   <= '0;
      RSP_ERR   <= 1'b0;
      CMD_CNT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            A        <= CMD_A;
            B        <= CMD_B;
            ALU_FUN  <= CMD_FUN;
            RSP_FUN  <= CMD_FUN;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // The counter reaches RESULT_LAT on the cycle whose closing edge samples the result.
          if (wait_cnt == LAT_CNT) begin
            RSP_DATA  <= sel_data;
            RSP_CARRY <= sel_carry;
            RSP_ERR   <= ~sel_flag;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            CMD_CNT   <= CMD_CNT + 8'd1;
            ALU_FUN   <= FUN_NOP;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
